// File: rtl/bpred_gselect_pkg.sv
// Shared constants, types and helpers for the gselect branch predictor.
// Debug select encodings are used only when BPRED_DEBUG_EN is defined.
package bpred_pkg;

    localparam int unsigned HIST_W    = 6;
    localparam int unsigned PCIDX_W   = 6;
    localparam int unsigned IDX_W     = HIST_W + PCIDX_W;
    localparam int unsigned BTB_DEPTH = 64;
    localparam int unsigned TBL_DEPTH = 1 << IDX_W;

    typedef logic [1:0]       ctr_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam ctr_t CTR_INIT = 2'b01;

    typedef enum logic [31:0] {
        DBG_PC   = 32'd0,
        DBG_GHR  = 32'd1,
        DBG_IDX  = 32'd2,
        DBG_CTR  = 32'd3,
        DBG_BTB  = 32'd4
    } dbg_sel_e;

    // Two-bit saturating counter step.
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        if (taken && c != 2'b11) begin
            n = c + 2'b01;
        end else if (!taken && c != 2'b00) begin
            n = c - 2'b01;
        end
        return n;
    endfunction

endpackage

// File: rtl/bpred_gselect_if.sv
// Fetch/execute/preload/debug signal bundle of the gselect predictor.
interface bpred_gselect_if;
    import bpred_pkg::*;

    logic               insnMem_wren;
    logic [31:0]        insnMem_data_w;
    logic [29:0]        up_btb_data;
    logic [HIST_W-1:0]  up_carry_data;
    logic [HIST_W-1:0]  bit_carry;
    logic               soin_bpredictor_stall;
    logic               bpredictor_fetch_p_dir;
    idx_t               bpredictor_fetch_bimodal;
    logic               execute_bpredictor_update;
    logic [31:0]        execute_bpredictor_PC4;
    logic [31:0]        execute_bpredictor_target;
    logic               execute_bpredictor_dir;
    logic               execute_bpredictor_miss;
    idx_t               execute_bpredictor_bimodal;
    logic [31:0]        soin_bpredictor_debug_sel;
    logic [31:0]        bpredictor_soin_debug;

    modport slave (
        input  insnMem_wren, insnMem_data_w, up_btb_data, up_carry_data,
        input  soin_bpredictor_stall,
        input  execute_bpredictor_update, execute_bpredictor_PC4,
        input  execute_bpredictor_target, execute_bpredictor_dir,
        input  execute_bpredictor_miss, execute_bpredictor_bimodal,
        input  soin_bpredictor_debug_sel,
        output bit_carry, bpredictor_fetch_p_dir, bpredictor_fetch_bimodal,
        output bpredictor_soin_debug
    );

    modport master (
        output insnMem_wren, insnMem_data_w, up_btb_data, up_carry_data,
        output soin_bpredictor_stall,
        output execute_bpredictor_update, execute_bpredictor_PC4,
        output execute_bpredictor_target, execute_bpredictor_dir,
        output execute_bpredictor_miss, execute_bpredictor_bimodal,
        output soin_bpredictor_debug_sel,
        input  bit_carry, bpredictor_fetch_p_dir, bpredictor_fetch_bimodal,
        input  bpredictor_soin_debug
    );

endinterface

// File: rtl/bpred_gselect_ctr_table.sv
// 4096 x 2-bit saturating counter table: async read, one training write per cycle.
module bpred_ctr_table
    import bpred_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  idx_t rd_idx,
    output ctr_t rd_ctr,
    input  logic wr_en,
    input  idx_t wr_idx,
    input  logic wr_taken
);

    ctr_t mem [TBL_DEPTH];

    assign rd_ctr = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '{default: CTR_INIT};
        end else if (wr_en) begin
            mem[wr_idx] <= ctr_next(mem[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/bpred_gselect.sv
// Gselect predictor top: fetch PC sequencer, GHR, 64-entry BTB, counter table.
// Optional debug readout mux is built only when BPRED_DEBUG_EN is defined.
module bpred_gselect
    import bpred_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    bpred_gselect_if.slave bus
);

    logic [31:0]        pc;
    logic [HIST_W-1:0]  ghr;
    logic [29:0]        btb [BTB_DEPTH];
    logic [PCIDX_W-1:0] pc_slot;
    logic [PCIDX_W-1:0] trn_slot;
    logic [PCIDX_W-1:0] pre_slot;
    logic [31:0]        trn_pc;
    logic [31:0]        btb_tgt;
    idx_t               idx;
    ctr_t               ctr_rd;

    assign pc_slot  = pc[7:2];
    assign idx      = {ghr, pc_slot};
    assign btb_tgt  = {btb[pc_slot], 2'b00};
    assign trn_pc   = bus.execute_bpredictor_PC4 - 32'd4;
    assign trn_slot = trn_pc[7:2];
    assign pre_slot = bus.insnMem_data_w[7:2];

    bpred_ctr_table u_ctr_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx),
        .rd_ctr   (ctr_rd),
        .wr_en    (bus.execute_bpredictor_update),
        .wr_idx   (bus.execute_bpredictor_bimodal),
        .wr_taken (bus.execute_bpredictor_dir)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
        end else if (bus.insnMem_wren) begin
            pc <= bus.insnMem_data_w;
        end else if (bus.execute_bpredictor_update && bus.execute_bpredictor_miss) begin
            pc <= bus.execute_bpredictor_dir ? bus.execute_bpredictor_target
                                             : bus.execute_bpredictor_PC4;
        end else if (bus.soin_bpredictor_stall) begin
            pc <= pc;
        end else if (ctr_rd[1]) begin
            pc <= btb_tgt;
        end else begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (bus.insnMem_wren) begin
            ghr <= bus.up_carry_data;
        end else if (bus.execute_bpredictor_update) begin
            ghr <= {ghr[HIST_W-2:0], bus.execute_bpredictor_dir};
        end
    end

    // Preload is written last so it overrides a training write to the same entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            btb <= '{default: '0};
        end else begin
            if (bus.execute_bpredictor_update && bus.execute_bpredictor_dir) begin
                btb[trn_slot] <= bus.execute_bpredictor_target[31:2];
            end
            if (bus.insnMem_wren) begin
                btb[pre_slot] <= bus.up_btb_data;
            end
        end
    end

    assign bus.bit_carry                = ghr;
    assign bus.bpredictor_fetch_p_dir   = ctr_rd[1];
    assign bus.bpredictor_fetch_bimodal = idx;

`ifdef BPRED_DEBUG_EN
    logic unused_bits;
    assign unused_bits = ^{trn_pc[31:8], trn_pc[1:0]};

    always_comb begin
        bus.bpredictor_soin_debug = '0;
        case (bus.soin_bpredictor_debug_sel)
            DBG_PC:  bus.bpredictor_soin_debug = pc;
            DBG_GHR: bus.bpredictor_soin_debug = {26'b0, ghr};
            DBG_IDX: bus.bpredictor_soin_debug = {20'b0, idx};
            DBG_CTR: bus.bpredictor_soin_debug = {30'b0, ctr_rd};
            DBG_BTB: bus.bpredictor_soin_debug = btb_tgt;
            default: bus.bpredictor_soin_debug = '0;
        endcase
    end
`else
    logic unused_bits;
    assign unused_bits = ^{trn_pc[31:8], trn_pc[1:0], ctr_rd[0],
                           bus.soin_bpredictor_debug_sel};

    assign bus.bpredictor_soin_debug = '0;
`endif

endmodule

// File: tb/tb_bpred_gselect.sv
// Directed-vector bench for bpred_gselect; debug expectations follow BPRED_DEBUG_EN.
module tb_bpred_gselect;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    bpred_gselect_if bus ();

    bpred_gselect dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dbg_exp(input logic [31:0] v);
`ifdef BPRED_DEBUG_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.insnMem_wren               = 1'b0;
        bus.insnMem_data_w             = '0;
        bus.up_btb_data                = '0;
        bus.up_carry_data              = '0;
        bus.soin_bpredictor_stall      = 1'b0;
        bus.execute_bpredictor_update  = 1'b0;
        bus.execute_bpredictor_PC4     = '0;
        bus.execute_bpredictor_target  = '0;
        bus.execute_bpredictor_dir     = 1'b0;
        bus.execute_bpredictor_miss    = 1'b0;
        bus.execute_bpredictor_bimodal = '0;
        bus.soin_bpredictor_debug_sel  = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic train(input logic [11:0] b, input logic d);
        bus.execute_bpredictor_update  = 1'b1;
        bus.execute_bpredictor_bimodal = b;
        bus.execute_bpredictor_dir     = d;
    endtask

    task automatic preload(input logic [31:0] pcv, input logic [29:0] btbv, input logic [5:0] hv);
        bus.insnMem_wren   = 1'b1;
        bus.insnMem_data_w = pcv;
        bus.up_btb_data    = btbv;
        bus.up_carry_data  = hv;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // Reset and sequential fetch
        do_reset();
        check("rst_pdir",  {31'b0, bus.bpredictor_fetch_p_dir}, 32'd0);
        check("rst_bim",   {20'b0, bus.bpredictor_fetch_bimodal}, 32'd0);
        check("rst_ghr",   {26'b0, bus.bit_carry}, 32'd0);
        bus.soin_bpredictor_debug_sel = 32'd0;
        #1;
        check("rst_dbg_pc", bus.bpredictor_soin_debug, dbg_exp(32'd0));
        bus.soin_bpredictor_debug_sel = 32'd0;
        step();
        check("seq_bim1",  {20'b0, bus.bpredictor_fetch_bimodal}, 32'd1);
        check("seq_pdir1", {31'b0, bus.bpredictor_fetch_p_dir}, 32'd0);
        step();
        check("seq_bim2",  {20'b0, bus.bpredictor_fetch_bimodal}, 32'd2);

        // Taken training into idx 3, GHR fills with ones
        do_reset();
        train(12'd3, 1'b1);
        bus.execute_bpredictor_PC4    = 32'd128;
        bus.execute_bpredictor_target = 32'd0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("train_ghr%0d", k), {26'b0, bus.bit_carry}, (32'd1 << k) - 32'd1);
        end
        // 7th taken update lands with a preload: counter still trains, preload owns GHR
        preload(32'd12, 30'h40, 6'd0);
        step();
        idle();
        check("pre_ghr0",  {26'b0, bus.bit_carry}, 32'd0);
        check("sat_bim3",  {20'b0, bus.bpredictor_fetch_bimodal}, 32'd3);
        check("sat_pdir",  {31'b0, bus.bpredictor_fetch_p_dir}, 32'd1);
        bus.soin_bpredictor_debug_sel = 32'd3;
        #1;
        check("sat_dbg_ctr", bus.bpredictor_soin_debug, dbg_exp(32'd3));
        bus.soin_bpredictor_debug_sel = 32'd0;
        bus.soin_bpredictor_stall = 1'b1;
        step();
        check("tk_stall_bim", {20'b0, bus.bpredictor_fetch_bimodal}, 32'd3);
        bus.soin_bpredictor_stall = 1'b0;
        step();
        check("tk_redir_bim", {20'b0, bus.bpredictor_fetch_bimodal}, 32'd0);
        check("tk_redir_pdir", {31'b0, bus.bpredictor_fetch_p_dir}, 32'd0);
        step();
        check("tk_seq_bim", {20'b0, bus.bpredictor_fetch_bimodal}, 32'd1);

        // PC wraps modulo 2^32
        preload(32'hFFFF_FFFC, 30'd0, 6'd0);
        step();
        idle();
        check("wrap_bim63", {20'b0, bus.bpredictor_fetch_bimodal}, 32'd63);
        step();
        check("wrap_bim0",  {20'b0, bus.bpredictor_fetch_bimodal}, 32'd0);

        // Preload PC/GHR/BTB
        preload(32'h40, 30'hF, 6'b100111);
        step();
        idle();
        check("pl_ghr",  {26'b0, bus.bit_carry}, 32'h27);
        check("pl_bim",  {20'b0, bus.bpredictor_fetch_bimodal}, 32'h9D0);
        check("pl_pdir", {31'b0, bus.bpredictor_fetch_p_dir}, 32'd0);
        bus.soin_bpredictor_debug_sel = 32'd4;
        #1;
        check("pl_dbg_btb", bus.bpredictor_soin_debug, dbg_exp(32'h3C));
        bus.soin_bpredictor_debug_sel = 32'd7;
        #1;
        check("pl_dbg_other", bus.bpredictor_soin_debug, 32'd0);
        bus.soin_bpredictor_debug_sel = 32'd1;
        #1;
        check("pl_dbg_ghr", bus.bpredictor_soin_debug, dbg_exp(32'h27));
        bus.soin_bpredictor_debug_sel = 32'd0;

        // Mispredict redirect overrides stall
        train(12'h9D0, 1'b0);
        bus.execute_bpredictor_miss   = 1'b1;
        bus.execute_bpredictor_PC4    = 32'h84;
        bus.soin_bpredictor_stall     = 1'b1;
        step();
        check("miss_nt_ghr", {26'b0, bus.bit_carry}, 32'h0E);
        check("miss_nt_bim", {20'b0, bus.bpredictor_fetch_bimodal}, 32'h3A1);
        bus.execute_bpredictor_dir    = 1'b1;
        bus.execute_bpredictor_target = 32'h200;
        step();
        check("miss_tk_ghr", {26'b0, bus.bit_carry}, 32'h1D);
        check("miss_tk_bim", {20'b0, bus.bpredictor_fetch_bimodal}, 32'h740);
        idle();
        bus.soin_bpredictor_stall = 1'b1;
        step();
        check("stall_hold_bim", {20'b0, bus.bpredictor_fetch_bimodal}, 32'h740);
        idle();

        // Down-saturation at idx 5, then climb back
        do_reset();
        bus.soin_bpredictor_stall = 1'b1;
        train(12'd5, 1'b0);
        for (int k = 0; k < 4; k++) step();
        idle();
        preload(32'd20, 30'd0, 6'd0);
        step();
        idle();
        check("dec_bim5",  {20'b0, bus.bpredictor_fetch_bimodal}, 32'd5);
        check("dec_pdir",  {31'b0, bus.bpredictor_fetch_p_dir}, 32'd0);
        bus.soin_bpredictor_debug_sel = 32'd3;
        #1;
        check("dec_dbg_ctr", bus.bpredictor_soin_debug, dbg_exp(32'd0));
        bus.soin_bpredictor_debug_sel = 32'd0;
        preload(32'd20, 30'd0, 6'd0);
        train(12'd5, 1'b1);
        step();
        idle();
        check("inc1_pdir", {31'b0, bus.bpredictor_fetch_p_dir}, 32'd0);
        check("inc1_ghr",  {26'b0, bus.bit_carry}, 32'd0);
        preload(32'd20, 30'd0, 6'd0);
        train(12'd5, 1'b1);
        step();
        idle();
        check("inc2_pdir", {31'b0, bus.bpredictor_fetch_p_dir}, 32'd1);
        check("inc2_bim5", {20'b0, bus.bpredictor_fetch_bimodal}, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bpred_gselect.md
Name: bpred_gselect

Overview:
- Gselect branch predictor for the fetch stage: 4096-entry table of 2-bit saturating counters, indexed by {6-bit global history, fetch PC[7:2]}.
- Includes a 64-entry BTB and an internal fetch PC sequencer.
- Execute stage returns resolved branches for training and misprediction redirect.
- Preload port sets fetch PC, history and BTB entries for bring-up and test.

Parameters:
- HIST_W, 6, global history bits.
- PCIDX_W, 6, fetch PC bits used for indexing (PC[7:2]).
- IDX_W, 12, counter-table index width (HIST_W+PCIDX_W).
- CTR_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- insnMem_wren  in  1  preload strobe.
- insnMem_data_w  in  32  preload fetch PC; bits [7:2] also select the BTB entry.
- up_btb_data  in  30  preload BTB target word address.
- up_carry_data  in  6  preload global history value.
- bit_carry  out  6  current global history register (GHR).
- soin_bpredictor_stall  in  1  hold fetch PC.
- bpredictor_fetch_p_dir  out  1  predicted direction for current fetch PC.
- bpredictor_fetch_bimodal  out  12  table index used for that prediction; carried down the pipeline.
- execute_bpredictor_update  in  1  resolved branch valid.
- execute_bpredictor_PC4  in  32  branch PC+4.
- execute_bpredictor_target  in  32  resolved taken target.
- execute_bpredictor_dir  in  1  resolved direction (1 = taken).
- execute_bpredictor_miss  in  1  mispredicted; redirect fetch.
- execute_bpredictor_bimodal  in  12  index returned from fetch.
- soin_bpredictor_debug_sel  in  32  debug mux select.
- bpredictor_soin_debug  out  32  debug readout.

Behaviour:
- Reset (synchronous): fetch PC=0, GHR=0, all counters=CTR_INIT, all BTB entries=0.
  - Immediately after reset: p_dir=0, bimodal=0, bit_carry=0.
- Lookup (combinational, same cycle):
  - idx = {GHR, PC[7:2]}; bpredictor_fetch_bimodal = idx.
  - p_dir = ctr[idx][1].
  - btb_tgt = {BTB[PC[7:2]], 2'b00}.
- Next fetch PC, priority order:
  1. insnMem_wren: PC <= insnMem_data_w.
  2. update && miss: PC <= dir ? target : PC4.
  3. stall: PC holds.
  4. p_dir: PC <= btb_tgt.
  5. Otherwise: PC <= PC+4, wrapping modulo 2^32.
- Training, when update=1:
  - ctr[execute_bpredictor_bimodal] saturating +1 if dir, -1 if not. Saturates at 3 and 0.
  - GHR <= {GHR[4:0], dir}.
  - If dir=1: BTB[(PC4-4)[7:2]] <= target[31:2].
  - Training proceeds regardless of stall.
- Preload, when insnMem_wren=1:
  - GHR <= up_carry_data.
  - BTB[insnMem_data_w[7:2]] <= up_btb_data.
  - Preload wins over a same-cycle training write to GHR or to the same BTB entry.
  - Counter training still occurs in the same cycle.
- Read-during-write: lookup sees pre-edge contents; new values are visible the next cycle.
- Debug mux, on sel[31:0]:
  - 0: fetch PC.
  - 1: {26'b0, GHR}.
  - 2: {20'b0, idx}.
  - 3: {30'b0, ctr[idx]}.
  - 4: btb_tgt.
  - Any other value: 0.
- No handshakes; all state changes occur on the rising edge of clk.

Optional Feature:
- BPRED_DEBUG_EN
  - Defined: the debug mux operates as specified.
  - Undefined: bpredictor_soin_debug is tied to 32'b0, soin_bpredictor_debug_sel is ignored, and no debug logic is synthesized.

Decomposition:
- Shared package bpred_pkg holds:
  - constants HIST_W, PCIDX_W, IDX_W, CTR_INIT, BTB_DEPTH=64;
  - typedefs ctr_t (2-bit) and idx_t (12-bit);
  - debug select encodings.
- Sub-module bpred_ctr_table: 4096x2 counter array with async read, saturating update and reset.

Test Plan:
- Reset, then hold update=0, stall=0 for 3 cycles:
  - PC goes 0,4,8; p_dir=0; bimodal = 0, 1, 2.
- Train: reset, then update=1, dir=1, miss=0, bimodal=3, PC4=128, target=0, held for 6 cycles:
  - bit_carry steps 000001, 000011, … up to 111111.
  - ctr[3] reaches 3 after 2 updates, then stays saturated.
  - BTB[31]=0.
- Preload: insnMem_wren=1, data_w=32'h40, up_btb_data=30'hF, up_carry_data=6'b100111:
  - Next cycle PC=0x40, bit_carry=6'b100111, BTB[16]=0xF.
  - Debug sel=4 reads 0x3C.
- Mispredict: update=1, miss=1, dir=0, PC4=0x84 with stall=1:
  - PC becomes 0x84 (miss overrides stall).
  - With dir=1 and target=0x200: PC becomes 0x200.
- Predicted taken:
  - Setup: counter at the current idx trained to 2 or 3, and its BTB entry preloaded to 0x100.
  - Required: p_dir=1 and next PC=0x100. With stall=1 the PC holds.
- Saturation/decrement:
  - 4 not-taken updates to idx 5 from reset give ctr[5]=0.
  - Debug sel=3 at idx 5 reads 0.
